top_controller: RTL and testbench

Top-level UART edge-detection engine. It receives a grayscale image byte-by-byte over a UART line and stores it in an internal frame buffer. Once the frame is complete, it computes a Sobel gradient magnitude per pixel and streams the resulting edge image back over a UART transmit line. This block is the whole FPGA-side design; the host PC connects only through `rxd` and `txd`.

---
 rtl/top_controller.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_top_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_controller.sv
// top_controller: UART-fed frame buffer with a Sobel edge engine that streams
// the clamped gradient magnitude of every pixel back over a UART transmitter.
module top_controller #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned IMG_W        = 9,
    parameter int unsigned IMG_H        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic txd
);

    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
    typedef enum logic [1:0] {C_RECV, C_PROC, C_SEND} ctl_state_t;

    rx_state_t         r_rx_state;
    logic              r_rx_s1, r_rx_s2;
    logic [CW-1:0]     r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [7:0]        r_rx_shift;
    logic              r_rx_valid;

    logic              r_txd, r_tx_busy, r_tx_done, r_tx_start;
    logic [CW-1:0]     r_tx_cnt;
    logic [3:0]        r_tx_bits;
    logic [8:0]        r_tx_shift;
    logic [7:0]        r_tx_data;

    ctl_state_t        r_state;
    logic [AW-1:0]     r_wr_addr, r_k;
    logic [XW-1:0]     r_col;
    logic [YW-1:0]     r_row;
    logic [3:0]        r_tap, r_tap_d;
    logic              r_rd_vld;
    logic signed [10:0] r_gx, r_gy;
    logic [7:0]        r_mem [N];
    logic [7:0]        r_rd_data;

    logic [AW-1:0]     w_tap_off, w_rd_addr;
    logic              w_wr_en, w_border;
    logic signed [10:0] w_p1, w_p2, w_dx, w_dy;
    logic [10:0]       w_ax, w_ay;
    logic [11:0]       w_mag;
    logic [7:0]        w_out;

    assign txd = r_txd;

    // Receiver: synchronize rxd, validate start at half-bit, sample mid-bit, check stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_rx_cnt <= '0;
                        if (r_rx_s2) begin
                            r_rx_valid <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_WAITHI;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_WAITHI: if (r_rx_s2) r_rx_state <= RX_IDLE;
                default:   r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd      <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_done <= 1'b0;
            if (!r_tx_busy) begin
                if (r_tx_start) begin
                    r_tx_busy  <= 1'b1;
                    r_txd      <= 1'b0;
                    r_tx_shift <= {1'b1, r_tx_data};
                    r_tx_cnt   <= '0;
                    r_tx_bits  <= '0;
                end
            end else if (r_tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                r_tx_cnt <= '0;
                if (r_tx_bits == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_done <= 1'b1;
                    r_txd     <= 1'b1;
                end else begin
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                    r_tx_bits  <= r_tx_bits + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    // Window tap offset relative to the top-left neighbour of pixel k.
    always_comb begin
        w_tap_off = '0;
        case (r_tap)
            4'd1:    w_tap_off = AW'(1);
            4'd2:    w_tap_off = AW'(2);
            4'd3:    w_tap_off = AW'(IMG_W);
            4'd4:    w_tap_off = AW'(IMG_W + 1);
            4'd5:    w_tap_off = AW'(IMG_W + 2);
            4'd6:    w_tap_off = AW'(2 * IMG_W);
            4'd7:    w_tap_off = AW'(2 * IMG_W + 1);
            4'd8:    w_tap_off = AW'(2 * IMG_W + 2);
            default: w_tap_off = '0;
        endcase
    end

    assign w_rd_addr = r_k - AW'(IMG_W + 1) + w_tap_off;
    assign w_wr_en   = (r_state == C_RECV) && r_rx_valid;
    assign w_border  = (r_row == '0) || (r_row == YW'(IMG_H - 1)) ||
                       (r_col == '0) || (r_col == XW'(IMG_W - 1));
    assign w_p1      = signed'({3'b000, r_rd_data});
    assign w_p2      = signed'({2'b00, r_rd_data, 1'b0});

    // Sobel weight contribution of the tap whose data just arrived.
    always_comb begin
        w_dx = '0;
        w_dy = '0;
        case (r_tap_d)
            4'd0: begin w_dx = -w_p1; w_dy = -w_p1; end
            4'd1: w_dy = -w_p2;
            4'd2: begin w_dx = w_p1;  w_dy = -w_p1; end
            4'd3: w_dx = -w_p2;
            4'd5: w_dx = w_p2;
            4'd6: begin w_dx = -w_p1; w_dy = w_p1;  end
            4'd7: w_dy = w_p2;
            4'd8: begin w_dx = w_p1;  w_dy = w_p1;  end
            default: begin w_dx = '0; w_dy = '0; end
        endcase
    end

    assign w_ax  = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
    assign w_ay  = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
    assign w_mag = 12'(w_ax) + 12'(w_ay);
    assign w_out = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];

    // Frame buffer: one write port from the receiver, one registered read port.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_addr] <= r_rx_shift;
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Controller: fill buffer, then per pixel read the 3x3 window, accumulate, send.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_RECV;
            r_wr_addr  <= '0;
            r_k        <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_tap      <= '0;
            r_tap_d    <= '0;
            r_rd_vld   <= 1'b0;
            r_gx       <= '0;
            r_gy       <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                C_RECV: begin
                    if (r_rx_valid) begin
                        if (r_wr_addr == AW'(N - 1)) begin
                            r_state  <= C_PROC;
                            r_k      <= '0;
                            r_row    <= '0;
                            r_col    <= '0;
                            r_tap    <= '0;
                            r_rd_vld <= 1'b0;
                            r_gx     <= '0;
                            r_gy     <= '0;
                        end else begin
                            r_wr_addr <= r_wr_addr + AW'(1);
                        end
                    end
                end
                C_PROC: begin
                    if (w_border) begin
                        r_tx_data  <= 8'h00;
                        r_tx_start <= 1'b1;
                        r_state    <= C_SEND;
                    end else begin
                        if (r_tap != 4'd9) begin
                            r_tap    <= r_tap + 4'd1;
                            r_tap_d  <= r_tap;
                            r_rd_vld <= 1'b1;
                        end else begin
                            r_rd_vld <= 1'b0;
                        end
                        if (r_rd_vld) begin
                            r_gx <= r_gx + w_dx;
                            r_gy <= r_gy + w_dy;
                        end
                        if (r_tap == 4'd9 && !r_rd_vld) begin
                            r_tx_data  <= w_out;
                            r_tx_start <= 1'b1;
                            r_state    <= C_SEND;
                        end
                    end
                end
                C_SEND: begin
                    if (r_tx_done) begin
                        if (r_k == AW'(N - 1)) begin
                            r_wr_addr <= '0;
                            r_k       <= '0;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_state   <= C_RECV;
                        end else begin
                            r_k <= r_k + AW'(1);
                            if (r_col == XW'(IMG_W - 1)) begin
                                r_col <= '0;
                                r_row <= r_row + YW'(1);
                            end else begin
                                r_col <= r_col + XW'(1);
                            end
                            r_tap    <= '0;
                            r_rd_vld <= 1'b0;
                            r_gx     <= '0;
                            r_gy     <= '0;
                            r_state  <= C_PROC;
                        end
                    end
                end
                default: r_state <= C_RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_top_controller.sv
// Bench for top_controller: drives UART images in, decodes UART bytes out and
// compares them with a direct Sobel evaluation of the image that was sent.
module tb_top_controller;

    localparam int CPB = 10;
    localparam int W   = 9;
    localparam int H   = 3;
    localparam int N   = W * H;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic txd;

    int checks = 0;
    int errors = 0;

    logic [7:0] img  [N];
    int         expv [N];

    always #5 clk = ~clk;

    top_controller #(.CLKS_PER_BIT(CPB), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .txd(txd)
    );

    // Safety net: the whole run is far shorter than this.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, required finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    function automatic int px(input int r, input int c);
        return int'(img[r * W + c]);
    endfunction

    function automatic int sobel(input int r, input int c);
        int gx, gy, m;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
        gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
           - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic build_expected();
        for (int k = 0; k < N; k++) expv[k] = sobel(k / W, k % W);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_byte(img[k], 1'b1);
    endtask

    // Waits (bounded) for a start bit, then decodes one 8N1 frame at mid-bit.
    task automatic get_byte(input int budget, output logic [7:0] b, output logic ok);
        int n;
        n  = 0;
        b  = '0;
        ok = 1'b0;
        while (txd !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (txd === 1'b0) begin
            ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            if (txd !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            if (txd !== 1'b1) ok = 1'b0;
            repeat (CPB / 2) @(negedge clk);
        end
    endtask

    task automatic recv_bytes(input string tag, input int count, input int first_budget);
        logic [7:0] b;
        logic       ok;
        for (int i = 0; i < count; i++) begin
            get_byte((i == 0) ? first_budget : 48, b, ok);
            check($sformatf("%s_frame%0d", tag, i), 32'(ok), 32'd1);
            check($sformatf("%s_px%0d", tag, i), 32'(b), 32'(expv[i]));
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    task automatic random_image();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) img[k] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            else img[k] = 8'($urandom_range(0, 255));
        end
        build_expected();
    endtask

    initial begin
        int n;

        // Reset with idle line: transmitter must stay quiet.
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_txd", 32'(txd), 32'd1);
        quiet("reset_idle", 300);

        // Ramp image 1..27.
        for (int k = 0; k < N; k++) img[k] = 8'(k + 1);
        build_expected();
        fork
            send_range(0, N - 1);
            recv_bytes("ramp", N, 4000);
        join

        // Saturation: row 0 black, rows 1..2 white.
        for (int k = 0; k < N; k++) img[k] = (k < W) ? 8'h00 : 8'hFF;
        build_expected();
        fork
            send_range(0, N - 1);
            recv_bytes("sat", N, 4000);
        join

        // Framing error and short glitch inserted mid-image must not be stored.
        random_image();
        fork
            begin
                send_range(0, 3);
                send_byte(8'($urandom_range(0, 255)), 1'b0);
                repeat (2 * CPB) @(negedge clk);
                rxd = 1'b0;
                repeat (2) @(negedge clk);
                rxd = 1'b1;
                repeat (2 * CPB) @(negedge clk);
                send_range(4, N - 1);
            end
            recv_bytes("ferr", N, 4000);
        join

        // Reset during the 6th output byte, then a full ramp image again.
        for (int k = 0; k < N; k++) img[k] = 8'(k + 1);
        build_expected();
        fork
            send_range(0, N - 1);
            recv_bytes("pre_rst", 5, 4000);
        join
        n = 0;
        while (txd !== 1'b0 && n < 48) begin
            @(negedge clk);
            n++;
        end
        check("byte5_started", 32'(txd), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", 32'(txd), 32'd1);
        rst = 1'b0;
        quiet("rst_mid_idle", 200);
        fork
            send_range(0, N - 1);
            recv_bytes("post_rst", N, 4000);
        join

        // Back-to-back random images; bytes sent while the output streams are ignored.
        random_image();
        fork
            send_range(0, N - 1);
            recv_bytes("imgA", N, 4000);
        join
        random_image();
        fork
            begin
                send_range(0, N - 1);
                repeat (40) @(negedge clk);
                for (int j = 0; j < 4; j++) send_byte(8'($urandom_range(0, 255)), 1'b1);
            end
            recv_bytes("imgB", N, 4000);
        join
        random_image();
        fork
            send_range(0, N - 1);
            recv_bytes("imgC", N, 4000);
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
